// File: rtl/usb_crc16_stream.sv
//------------------------------------------------------------------------------
// usb_crc16_stream
//
// Streaming USB CRC16 checker/generator. Beats pass through a single output
// register unchanged. The USB CRC16 (reflected poly 0xA001, init 0xFFFF,
// LSB-first, lane 0 first) runs over every kept byte. One cycle after the last
// beat of a packet is accepted, a one-cycle crc_valid strobe is raised together
// with the inverted CRC (transmit form) and the residue check result.
//
// Optional feature macro: USB_CRC16_STREAM_GEN_EN
//   When defined, the block appends the CRC (low byte first) as a tail after
//   each packet. The original last beat leaves with m_last=0 and the tail
//   carries m_last=1. When undefined, the block is a pure pass-through checker.
//
// Parameters:
//   DATA_BYTES  bytes per beat (1, 2 or 4)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     input handshake
//   s_data/s_keep       input bytes (lane 0 = bits 7:0, first on the wire), lane enables
//   s_last              final beat of packet
//   m_valid/m_ready     registered output handshake
//   m_data/m_keep       output bytes / lane enables
//   m_last              final output beat of packet
//   crc_valid           one-cycle end-of-packet strobe
//   crc_value           ~CRC of the packet, held until the next strobe
//   crc_ok              residue check result, held until the next strobe
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module usb_crc16_stream #(
    parameter int DATA_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [8*DATA_BYTES-1:0] m_data,
    output logic [DATA_BYTES-1:0]   m_keep,
    output logic                    m_last,
    output logic                    crc_valid,
    output logic [15:0]             crc_value,
    output logic                    crc_ok
);

    localparam int          W           = 8 * DATA_BYTES;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUE = 16'hB001;

`ifdef USB_CRC16_STREAM_GEN_EN
    typedef enum logic [1:0] {ST_DATA, ST_TAIL0, ST_TAIL1} state_t;
    state_t state_q, state_d;
`endif

    logic [15:0]   crc_q, crc_d, crc_next;
    logic          m_valid_q, m_valid_d;
    logic [W-1:0]  m_data_q, m_data_d;
    logic [DATA_BYTES-1:0] m_keep_q, m_keep_d;
    logic          m_last_q, m_last_d;
    logic          crc_valid_q, crc_valid_d;
    logic [15:0]   crc_value_q, crc_value_d;
    logic          crc_ok_q, crc_ok_d;
    logic          out_free;
    logic          accept;

    // One byte of the reflected CRC16, bit 0 of the byte enters first.
    function automatic logic [15:0] crc_byte(input logic [15:0] r, input logic [7:0] b);
        logic [15:0] c;
        c = r;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = {1'b0, c[15:1]} ^ 16'hA001;
            else             c = {1'b0, c[15:1]};
        end
        return c;
    endfunction

    // The output register can take a new beat when empty or being drained.
    assign out_free = !m_valid_q || m_ready;
`ifdef USB_CRC16_STREAM_GEN_EN
    assign s_ready  = !rst && out_free && (state_q == ST_DATA);
`else
    assign s_ready  = !rst && out_free;
`endif
    assign accept   = s_valid && s_ready;

    // CRC after folding in every kept lane of the current beat, lanes ascending.
    always_comb begin
        crc_next = crc_q;
        for (int lane = 0; lane < DATA_BYTES; lane++) begin
            if (s_keep[lane]) crc_next = crc_byte(crc_next, s_data[8*lane +: 8]);
        end
    end

    // Next-state logic: load accepted beats, drain on m_ready, publish the CRC
    // result at end of packet and (generator build) sequence the CRC tail.
    always_comb begin
        crc_d       = crc_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        crc_valid_d = 1'b0;
        crc_value_d = crc_value_q;
        crc_ok_d    = crc_ok_q;
`ifdef USB_CRC16_STREAM_GEN_EN
        state_d     = state_q;
`endif
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data;
            m_keep_d  = s_keep;
            m_last_d  = s_last;
            if (s_last) begin
                crc_d       = CRC_INIT;
                crc_valid_d = 1'b1;
                crc_value_d = ~crc_next;
                crc_ok_d    = (crc_next == CRC_RESIDUE);
`ifdef USB_CRC16_STREAM_GEN_EN
                m_last_d    = 1'b0;
                state_d     = ST_TAIL0;
`endif
            end else begin
                crc_d = crc_next;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
`ifdef USB_CRC16_STREAM_GEN_EN
        // The tail is loaded once the payload's last beat has left the register;
        // crc_value_q is already valid in the first TAIL0 cycle.
        if (out_free && state_q == ST_TAIL0) begin
            m_valid_d = 1'b1;
            if (DATA_BYTES == 1) begin
                m_data_d = W'(crc_value_q[7:0]);
                m_keep_d = DATA_BYTES'(1);
                m_last_d = 1'b0;
                state_d  = ST_TAIL1;
            end else begin
                m_data_d = W'(crc_value_q);
                m_keep_d = DATA_BYTES'(3);
                m_last_d = 1'b1;
                state_d  = ST_DATA;
            end
        end else if (out_free && state_q == ST_TAIL1) begin
            m_valid_d = 1'b1;
            m_data_d  = W'(crc_value_q[15:8]);
            m_keep_d  = DATA_BYTES'(1);
            m_last_d  = 1'b1;
            state_d   = ST_DATA;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q       <= CRC_INIT;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            crc_valid_q <= 1'b0;
            crc_value_q <= 16'h0000;
            crc_ok_q    <= 1'b0;
`ifdef USB_CRC16_STREAM_GEN_EN
            state_q     <= ST_DATA;
`endif
        end else begin
            crc_q       <= crc_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            crc_valid_q <= crc_valid_d;
            crc_value_q <= crc_value_d;
            crc_ok_q    <= crc_ok_d;
`ifdef USB_CRC16_STREAM_GEN_EN
            state_q     <= state_d;
`endif
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_keep    = m_keep_q;
    assign m_last    = m_last_q;
    assign crc_valid = crc_valid_q;
    assign crc_value = crc_value_q;
    assign crc_ok    = crc_ok_q;

endmodule

// File: tb/tb_usb_crc16_stream.sv
//------------------------------------------------------------------------------
// tb_usb_crc16_stream
//
// Drives three instances (1, 2 and 4 bytes per beat) from one shared stimulus
// bus; 'sel' picks the active instance, the others idle. Expected output beats
// and CRC events come from a byte-level model of the USB CRC16 and the
// stream rules, and are compared against what a negedge monitor records.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_crc16_stream;

    typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
    typedef struct packed { logic [15:0] v; logic ok; logic [31:0] cyc; } crc_ev_t;

    logic        clk = 1'b0;
    logic        rst, sv, sl, mr, stall_en;
    logic [31:0] sd;
    logic [3:0]  sk;
    int          sel, cur_db;

    logic sr1, mv1, ml1, cv1, cok1; logic [7:0]  md1; logic [0:0] mk1; logic [15:0] cval1;
    logic sr2, mv2, ml2, cv2, cok2; logic [15:0] md2; logic [1:0] mk2; logic [15:0] cval2;
    logic sr4, mv4, ml4, cv4, cok4; logic [31:0] md4; logic [3:0] mk4; logic [15:0] cval4;

    logic        o_sready, o_mv, o_ml, o_cv, o_cok;
    logic [31:0] o_md;
    logic [3:0]  o_mk;
    logic [15:0] o_cval;

    int          tests, fails, timeouts, stall_err;
    logic [31:0] cyc;
    beat_t       exp_beats[$], got_beats[$];
    crc_ev_t     exp_crc[$], got_crc[$];
    logic [31:0] acc_cyc[$];
    logic        prev_hold;
    beat_t       prev_beat;

    always #5 clk = ~clk;

    usb_crc16_stream #(.DATA_BYTES(1)) dut1 (
        .clk(clk), .rst(rst), .s_valid(sv && (sel == 1)), .s_ready(sr1), .s_data(sd[7:0]),
        .s_keep(sk[0:0]), .s_last(sl), .m_valid(mv1), .m_ready(mr || (sel != 1)), .m_data(md1),
        .m_keep(mk1), .m_last(ml1), .crc_valid(cv1), .crc_value(cval1), .crc_ok(cok1));
    usb_crc16_stream #(.DATA_BYTES(2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(sv && (sel == 2)), .s_ready(sr2), .s_data(sd[15:0]),
        .s_keep(sk[1:0]), .s_last(sl), .m_valid(mv2), .m_ready(mr || (sel != 2)), .m_data(md2),
        .m_keep(mk2), .m_last(ml2), .crc_valid(cv2), .crc_value(cval2), .crc_ok(cok2));
    usb_crc16_stream #(.DATA_BYTES(4)) dut4 (
        .clk(clk), .rst(rst), .s_valid(sv && (sel == 4)), .s_ready(sr4), .s_data(sd),
        .s_keep(sk), .s_last(sl), .m_valid(mv4), .m_ready(mr || (sel != 4)), .m_data(md4),
        .m_keep(mk4), .m_last(ml4), .crc_valid(cv4), .crc_value(cval4), .crc_ok(cok4));

    always_comb begin
        case (sel)
            1: begin
                o_sready = sr1; o_mv = mv1; o_md = {24'h0, md1}; o_mk = {3'b0, mk1};
                o_ml = ml1; o_cv = cv1; o_cval = cval1; o_cok = cok1;
            end
            2: begin
                o_sready = sr2; o_mv = mv2; o_md = {16'h0, md2}; o_mk = {2'b0, mk2};
                o_ml = ml2; o_cv = cv2; o_cval = cval2; o_cok = cok2;
            end
            default: begin
                o_sready = sr4; o_mv = mv4; o_md = md4; o_mk = mk4;
                o_ml = ml4; o_cv = cv4; o_cval = cval4; o_cok = cok4;
            end
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Random output back-pressure, applied just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mr = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: records transfers and CRC strobes, and counts any change or
    // loss of a beat that is being held under back-pressure.
    always @(negedge clk) begin : mon
        beat_t   cur;
        crc_ev_t ev;
        cur = {o_md, o_mk, o_ml};
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (!o_mv || cur !== prev_beat)) stall_err++;
            if (o_mv && mr) got_beats.push_back(cur);
            if (o_cv) begin
                ev.v = o_cval; ev.ok = o_cok; ev.cyc = cyc;
                got_crc.push_back(ev);
            end
            prev_hold = o_mv && !mr;
            prev_beat = cur;
        end
    end

    // USB CRC16 over a whole packet, straight from the polynomial definition.
    function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = r[0] ^ b[i][k];
                r  = r >> 1;
                if (fb) r = r ^ 16'hA001;
            end
        end
        return r;
    endfunction

    function automatic void digits(output logic [7:0] q[$]);
        q.delete();
        for (int i = 1; i <= 9; i++) q.push_back(8'(8'h30 + i));
    endfunction

    task automatic set_sel(input int k);
        sel = k;
        cur_db = k;
    endtask

    task automatic clear_sb();
        exp_beats.delete(); got_beats.delete();
        exp_crc.delete(); got_crc.delete(); acc_cyc.delete();
    endtask

    task automatic drain();
        stall_en = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Present one beat until accepted and record what the outputs must show.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [15:0] r);
        int          waited;
        logic        got;
        logic [31:0] dm;
        logic [3:0]  km;
        logic [15:0] cv;
        crc_ev_t     ev;
        dm = (cur_db == 4) ? d : (d & ((32'h1 << (8 * cur_db)) - 32'h1));
        km = k & 4'((1 << cur_db) - 1);
        cv = ~r;
        sv = 1'b1; sd = d; sk = k; sl = l;
        waited = 0; got = 1'b0;
        while (!got && waited < 300) begin
            @(negedge clk);
            if (o_sready) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            timeouts++;
        end else begin
            acc_cyc.push_back(cyc);
            if (l) begin
                ev.v = cv; ev.ok = (r == 16'hB001); ev.cyc = cyc + 1;
                exp_crc.push_back(ev);
`ifdef USB_CRC16_STREAM_GEN_EN
                exp_beats.push_back({dm, km, 1'b0});
                if (cur_db == 1) begin
                    exp_beats.push_back({24'h0, cv[7:0], 4'b0001, 1'b0});
                    exp_beats.push_back({24'h0, cv[15:8], 4'b0001, 1'b1});
                end else begin
                    exp_beats.push_back({16'h0, cv, 4'b0011, 1'b1});
                end
`else
                exp_beats.push_back({dm, km, 1'b1});
`endif
            end else begin
                exp_beats.push_back({dm, km, 1'b0});
            end
        end
        @(posedge clk);
        #1;
        sv = 1'b0;
    endtask

    // Split a packet into beats; unused lanes carry random junk.
    task automatic send_packet(input logic [7:0] b[$], input logic empty_last, input logic gaps);
        int          n, nb, cnt;
        logic [31:0] d;
        logic [3:0]  k;
        logic [15:0] r;
        n  = b.size();
        r  = model_crc(b);
        nb = (n + cur_db - 1) / cur_db;
        if (n == 0 || (empty_last && (n % cur_db) == 0)) nb++;
        for (int bi = 0; bi < nb; bi++) begin
            cnt = n - bi * cur_db;
            if (cnt > cur_db) cnt = cur_db;
            if (cnt < 0) cnt = 0;
            d = $urandom;
            k = 4'b0;
            for (int j = 0; j < cnt; j++) begin
                d[8*j +: 8] = b[bi * cur_db + j];
                k[j] = 1'b1;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(d, k, (bi == nb - 1), r);
        end
    endtask

    task automatic test_reset();
        int k;
        set_sel(1);
        rst = 1'b1; sv = 1'b1; sd = 32'hA5A5A5A5; sk = 4'hF; sl = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            k = 1 << s;
            set_sel(k);
            #1;
            tests++; if (o_sready !== 1'b0) begin fails++; $display("[TB] FAIL reset_s_ready db%0d: got %b expected 0", k, o_sready); end
            tests++; if ({o_mv, o_ml, o_md, o_mk} !== 38'h0) begin fails++; $display("[TB] FAIL reset_m_stream db%0d: got %h expected 0", k, {o_mv, o_ml, o_md, o_mk}); end
            tests++; if ({o_cv, o_cok, o_cval} !== 18'h0) begin fails++; $display("[TB] FAIL reset_crc db%0d: got %h expected 0", k, {o_cv, o_cok, o_cval}); end
        end
        set_sel(1);
        @(posedge clk);
        #1;
        rst = 1'b0; sv = 1'b0;
        @(negedge clk);
        tests++; if (o_sready !== 1'b1) begin fails++; $display("[TB] FAIL release_s_ready: got %b expected 1", o_sready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_vector_residue();
        logic [7:0] pkt[$];
        set_sel(1); clear_sb();
        digits(pkt);
        pkt.push_back(8'hC8); pkt.push_back(8'hB4);
        send_packet(pkt, 1'b0, 1'b0);
        drain();
        tests++; if (got_beats.size() !== exp_beats.size()) begin fails++; $display("[TB] FAIL residue_beat_count: got %0d expected %0d", got_beats.size(), exp_beats.size()); end
        foreach (exp_beats[i]) if (i < got_beats.size()) begin
            tests++; if (got_beats[i] !== exp_beats[i]) begin fails++; $display("[TB] FAIL residue_beat[%0d]: got %h expected %h", i, got_beats[i], exp_beats[i]); end
        end
        tests++; if (got_crc.size() !== 1) begin fails++; $display("[TB] FAIL residue_crc_count: got %0d expected 1", got_crc.size()); end
        if (got_crc.size() > 0 && exp_crc.size() > 0) begin
            tests++; if (got_crc[0].ok !== 1'b1) begin fails++; $display("[TB] FAIL residue_crc_ok: got %b expected 1", got_crc[0].ok); end
            tests++; if (got_crc[0].v !== 16'h4FFE) begin fails++; $display("[TB] FAIL residue_crc_value: got %h expected 4ffe", got_crc[0].v); end
            tests++; if (got_crc[0].cyc !== exp_crc[0].cyc) begin fails++; $display("[TB] FAIL residue_crc_latency: got cycle %0d expected %0d", got_crc[0].cyc, exp_crc[0].cyc); end
        end
    endtask

    task automatic test_vector_plain();
        logic [7:0] pkt[$];
        set_sel(1); clear_sb();
        digits(pkt);
        send_packet(pkt, 1'b0, 1'b0);
        drain();
        tests++; if (got_crc.size() !== 1) begin fails++; $display("[TB] FAIL plain_crc_count: got %0d expected 1", got_crc.size()); end
        if (got_crc.size() > 0) begin
            tests++; if (got_crc[0].v !== 16'hB4C8) begin fails++; $display("[TB] FAIL plain_crc_value: got %h expected b4c8", got_crc[0].v); end
            tests++; if (got_crc[0].ok !== 1'b0) begin fails++; $display("[TB] FAIL plain_crc_ok: got %b expected 0", got_crc[0].ok); end
        end
        @(negedge clk);
        tests++; if ({o_cv, o_cok, o_cval} !== {2'b00, 16'hB4C8}) begin fails++; $display("[TB] FAIL plain_crc_hold: got %h expected 0b4c8", {o_cv, o_cok, o_cval}); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] pkt[$];
        set_sel(1); clear_sb();
        for (int i = 0; i < 4; i++) send_beat(32'(8'h41 + i), 4'b0001, 1'b0, 16'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests++; if ({o_mv, o_cv, o_cok, o_cval} !== 19'h0) begin fails++; $display("[TB] FAIL midrst_outputs: got %h expected 0", {o_mv, o_cv, o_cok, o_cval}); end
        @(posedge clk);
        #1;
        clear_sb();
        digits(pkt);
        pkt.push_back(8'hC8); pkt.push_back(8'hB4);
        send_packet(pkt, 1'b0, 1'b0);
        drain();
        tests++; if (got_crc.size() !== 1) begin fails++; $display("[TB] FAIL midrst_crc_count: got %0d expected 1", got_crc.size()); end
        if (got_crc.size() > 0) begin
            tests++; if (got_crc[0].ok !== 1'b1) begin fails++; $display("[TB] FAIL midrst_crc_ok: got %b expected 1", got_crc[0].ok); end
        end
        tests++; if (got_beats.size() !== exp_beats.size()) begin fails++; $display("[TB] FAIL midrst_beat_count: got %0d expected %0d", got_beats.size(), exp_beats.size()); end
    endtask

    task automatic test_wide4();
        logic [7:0] pkt[$];
        set_sel(4); clear_sb();
        digits(pkt);
        send_packet(pkt, 1'b0, 1'b0);
`ifdef USB_CRC16_STREAM_GEN_EN
        @(negedge clk);
        tests++; if (o_sready !== 1'b0) begin fails++; $display("[TB] FAIL wide_tail_s_ready: got %b expected 0", o_sready); end
        @(posedge clk);
        #1;
`endif
        pkt.delete();
        for (int i = 1; i <= 8; i++) pkt.push_back(8'(8'h30 + i));
        send_packet(pkt, 1'b1, 1'b0);
        drain();
        tests++; if (got_beats.size() !== exp_beats.size()) begin fails++; $display("[TB] FAIL wide_beat_count: got %0d expected %0d", got_beats.size(), exp_beats.size()); end
        foreach (exp_beats[i]) if (i < got_beats.size()) begin
            tests++; if (got_beats[i] !== exp_beats[i]) begin fails++; $display("[TB] FAIL wide_beat[%0d]: got %h expected %h", i, got_beats[i], exp_beats[i]); end
        end
        tests++; if (got_crc.size() !== exp_crc.size()) begin fails++; $display("[TB] FAIL wide_crc_count: got %0d expected %0d", got_crc.size(), exp_crc.size()); end
        foreach (exp_crc[i]) if (i < got_crc.size()) begin
            tests++; if (got_crc[i] !== exp_crc[i]) begin fails++; $display("[TB] FAIL wide_crc[%0d]: got %h expected %h", i, got_crc[i], exp_crc[i]); end
        end
        if (got_crc.size() > 0) begin
            tests++; if (got_crc[0].v !== 16'hB4C8) begin fails++; $display("[TB] FAIL wide_crc_value: got %h expected b4c8", got_crc[0].v); end
        end
    endtask

    task automatic test_random_stall();
        logic [7:0]  pkt[$];
        logic [15:0] r;
        int          len;
        set_sel(2); clear_sb();
        stall_err = 0; timeouts = 0;
        stall_en = 1'b1;
        for (int p = 0; p < 100; p++) begin
            pkt.delete();
            len = $urandom_range(0, 10);
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                r = ~model_crc(pkt);
                pkt.push_back(r[7:0]); pkt.push_back(r[15:8]);
            end
            send_packet(pkt, ($urandom_range(0, 3) == 0), 1'b1);
        end
        drain();
        tests++; if (timeouts !== 0) begin fails++; $display("[TB] FAIL rand_timeouts: got %0d expected 0", timeouts); end
        tests++; if (stall_err !== 0) begin fails++; $display("[TB] FAIL rand_stall_stable: got %0d violations expected 0", stall_err); end
        tests++; if (got_beats.size() !== exp_beats.size()) begin fails++; $display("[TB] FAIL rand_beat_count: got %0d expected %0d", got_beats.size(), exp_beats.size()); end
        foreach (exp_beats[i]) if (i < got_beats.size()) begin
            tests++; if (got_beats[i] !== exp_beats[i]) begin fails++; $display("[TB] FAIL rand_beat[%0d]: got %h expected %h", i, got_beats[i], exp_beats[i]); end
        end
        tests++; if (got_crc.size() !== exp_crc.size()) begin fails++; $display("[TB] FAIL rand_crc_count: got %0d expected %0d", got_crc.size(), exp_crc.size()); end
        foreach (exp_crc[i]) if (i < got_crc.size()) begin
            tests++; if (got_crc[i] !== exp_crc[i]) begin fails++; $display("[TB] FAIL rand_crc[%0d]: got %h expected %h", i, got_crc[i], exp_crc[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pkt[$];
        set_sel(1); clear_sb();
        timeouts = 0;
        for (int p = 0; p < 3; p++) begin
            pkt.delete();
            for (int i = 0; i < 2 + p; i++) pkt.push_back(8'($urandom));
            send_packet(pkt, 1'b0, 1'b0);
        end
        drain();
        tests++; if (timeouts !== 0) begin fails++; $display("[TB] FAIL b2b_timeouts: got %0d expected 0", timeouts); end
`ifndef USB_CRC16_STREAM_GEN_EN
        for (int i = 1; i < acc_cyc.size(); i++) begin
            tests++; if (acc_cyc[i] !== acc_cyc[i-1] + 1) begin fails++; $display("[TB] FAIL b2b_accept[%0d]: got cycle %0d expected %0d", i, acc_cyc[i], acc_cyc[i-1] + 1); end
        end
`endif
        tests++; if (got_crc.size() !== exp_crc.size()) begin fails++; $display("[TB] FAIL b2b_crc_count: got %0d expected %0d", got_crc.size(), exp_crc.size()); end
        foreach (exp_crc[i]) if (i < got_crc.size()) begin
            tests++; if (got_crc[i] !== exp_crc[i]) begin fails++; $display("[TB] FAIL b2b_crc[%0d]: got %h expected %h", i, got_crc[i], exp_crc[i]); end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; sv = 1'b0; sd = 32'h0; sk = 4'h0; sl = 1'b0;
        mr = 1'b1; stall_en = 1'b0; sel = 1; cur_db = 1; cyc = 32'h0;
        tests = 0; fails = 0; timeouts = 0; stall_err = 0; prev_hold = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_vector_residue();
        test_vector_plain();
        test_reset_mid_packet();
        test_wide4();
        test_random_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
